// File: rtl/tx_rate_pkg.sv
// rtl/tx_rate_pkg.sv - rate codes, divisor defaults, TX state encoding and rate lookup
package tx_rate_pkg;

  localparam logic [1:0] RATE_1 = 2'b00;
  localparam logic [1:0] RATE_5 = 2'b01;
  localparam logic [1:0] RATE_A = 2'b11;

  localparam int DEF_DIV_SLOW = 5208;
  localparam int DEF_DIV_MID  = 868;
  localparam int DEF_DIV_FAST = 434;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Unassigned code 2'b10 deliberately falls back to the slowest rate.
  function automatic logic [DIV_W-1:0] rate_div(
    input logic [1:0]       code,
    input logic [DIV_W-1:0] slow,
    input logic [DIV_W-1:0] mid,
    input logic [DIV_W-1:0] fast
  );
    case (code)
      RATE_5:  return mid;
      RATE_A:  return fast;
      default: return slow;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush, occupancy count and drop-on-full pulse
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             accept;
  logic             take;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign take    = rd_en & ~empty & ~flush;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign accept  = wr_en & (~full | take) & ~flush;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full & ~take;
      if (accept) wptr <= wptr + AW'(1);
      if (take)   rptr <= rptr + AW'(1);
      case ({accept, take})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_rate_buffer.sv
// rtl/tx_rate_buffer.sv - byte FIFO plus 8N1 UART transmitter with parser-selected baud divisor
module tx_rate_buffer
  import tx_rate_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DIV_SLOW = DEF_DIV_SLOW,
  parameter int DIV_MID  = DEF_DIV_MID,
  parameter int DIV_FAST = DEF_DIV_FAST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  input  logic [1:0]             rate_sel,
  input  logic                   rate_hold,
  input  logic                   finish,
  input  logic                   clean,
  output logic                   txd,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   overflow
);

  localparam logic [DIV_W-1:0] SLOW = DIV_W'(DIV_SLOW);
  localparam logic [DIV_W-1:0] MID  = DIV_W'(DIV_MID);
  localparam logic [DIV_W-1:0] FAST = DIV_W'(DIV_FAST);

  tx_state_t        state;
  tx_state_t        next_state;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       fifo_data;
  logic             bit_done;
  logic             pop;

  assign bit_done = (baud_cnt == '0);
  // Popping on the last stop-bit cycle lets the next start bit follow with no idle gap.
  assign pop = ~fifo_empty & ~rate_hold & ~clean &
               ((state == IDLE) | ((state == STOP) & bit_done));

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (clean),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      active_div <= SLOW;
    else if (clean)  active_div <= SLOW;
    else if (finish) active_div <= rate_div(rate_sel, SLOW, MID, FAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clean) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (pop) next_state = START;
        START:   if (bit_done) next_state = DATA;
        DATA:    if (bit_done && bit_idx == 3'd7) next_state = STOP;
        STOP:    if (bit_done) next_state = pop ? START : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // The divisor is latched per frame so a commit mid-frame only affects later frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_div  <= SLOW;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (clean) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (pop) begin
      shreg    <= fifo_data;
      cur_div  <= active_div;
      baud_cnt <= active_div - DIV_W'(1);
      bit_idx  <= '0;
    end else if (state != IDLE) begin
      if (bit_done) begin
        baud_cnt <= cur_div - DIV_W'(1);
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - DIV_W'(1);
      end
    end
  end

  always_comb begin
    txd     = 1'b1;
    tx_busy = (state != IDLE);
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_tx_rate_buffer.sv
// tb/tb_tx_rate_buffer.sv - scenario bench for tx_rate_buffer with line-level frame decoding
module tb_tx_rate_buffer;

  localparam int DEPTH = 16;
  localparam int DS = 20;
  localparam int DM = 8;
  localparam int DF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic [1:0] rate_sel = 2'b00;
  logic       rate_hold = 1'b0;
  logic       finish = 1'b0;
  logic       clean = 1'b0;
  logic       txd;
  logic       tx_busy;
  logic [4:0] fifo_cnt;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int model_div = DS;
  logic [7:0] exp_q[$];

  tx_rate_buffer #(.DEPTH(DEPTH), .DIV_SLOW(DS), .DIV_MID(DM), .DIV_FAST(DF)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .rate_sel(rate_sel),
    .rate_hold(rate_hold), .finish(finish), .clean(clean), .txd(txd), .tx_busy(tx_busy),
    .fifo_cnt(fifo_cnt), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int map_div(input logic [1:0] code);
    case (code)
      2'b01:   return DM;
      2'b11:   return DF;
      default: return DS;
    endcase
  endfunction

  task automatic write_byte(input logic [7:0] b, output logic ov);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    ov = overflow;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
  endtask

  task automatic commit_rate(input logic [1:0] code);
    @(negedge clk);
    rate_sel = code;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    model_div = map_div(code);
  endtask

  task automatic set_hold(input logic v);
    @(negedge clk);
    rate_hold = v;
  endtask

  // Samples one whole frame on the line; optionally pulses finish at sample fin_at.
  task automatic recv_frame(input int div, input bit now, input int fin_at, input logic [1:0] fin_rate,
                            output logic [7:0] data, output int gap, output bit ok);
    logic ts [10*DS];
    logic bs [10*DS];
    gap = 0;
    ok = 1'b1;
    data = 8'h00;
    if (!now) @(negedge clk);
    while (txd !== 1'b0 && gap < 400) begin
      gap++;
      @(negedge clk);
    end
    if (txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < 10*div; i++) begin
      if (i > 0) @(negedge clk);
      ts[i] = txd;
      bs[i] = tx_busy;
      if (i == fin_at) begin
        rate_sel = fin_rate;
        finish = 1'b1;
      end else if (i == fin_at + 1) begin
        finish = 1'b0;
      end
    end
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < div; j++)
        if (ts[b*div+j] !== ts[b*div] || bs[b*div+j] !== 1'b1) ok = 1'b0;
    if (ts[0] !== 1'b0 || ts[9*div] !== 1'b1) ok = 1'b0;
    for (int k = 0; k < 8; k++) data[k] = ts[(k+1)*div];
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_hold_txd: got %b want 1", txd); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
  endtask

  task automatic test_single_frame;
    logic ov;
    logic [7:0] d;
    int gap;
    bit ok;
    commit_rate(2'b11);
    write_byte(8'h41, ov);
    checks++; if (fifo_cnt !== 5'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", fifo_cnt); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL single_pre_txd: got %b want 1", txd); end
    recv_frame(model_div, 1'b0, -1, 2'b00, d, gap, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_shape: got %b want 1", ok); end
    checks++; if (gap !== 0) begin errors++; $display("FAIL single_latency: got %0d want 0", gap); end
    checks++; if (d !== exp_q.pop_front()) begin errors++; $display("FAIL single_data: got %h want 41", d); end
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", tx_busy); end
  endtask

  task automatic test_hold_contiguous;
    logic ov;
    logic [7:0] d, e;
    int gap;
    bit ok;
    set_hold(1'b1);
    commit_rate(2'b00);
    for (int i = 0; i < 3; i++) write_byte(8'($urandom), ov);
    repeat (4) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL hold_txd: got %b want 1", txd); end
    checks++; if (fifo_cnt !== 5'd3) begin errors++; $display("FAIL hold_cnt: got %0d want 3", fifo_cnt); end
    set_hold(1'b0);
    for (int i = 0; i < 3; i++) begin
      recv_frame(model_div, 1'b0, -1, 2'b00, d, gap, ok);
      e = exp_q.pop_front();
      checks++; if (ok !== 1'b1 || gap !== 0 || d !== e)
        begin errors++; $display("FAIL hold_frame%0d: got ok=%b gap=%0d data=%h want ok=1 gap=0 data=%h", i, ok, gap, d, e); end
    end
  endtask

  task automatic test_overflow;
    logic ov, last_ov;
    logic [7:0] d, e, extra;
    int ovc, gap, lows;
    bit ok;
    ovc = 0;
    last_ov = 1'b0;
    set_hold(1'b1);
    for (int i = 0; i < 17; i++) begin
      write_byte(8'($urandom), ov);
      if (ov === 1'b1) ovc++;
      if (i == 16) last_ov = ov;
    end
    checks++; if (ovc !== 1 || last_ov !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got count=%0d last=%b want 1 1", ovc, last_ov); end
    checks++; if (fifo_cnt !== 5'd16) begin errors++; $display("FAIL ovf_cnt: got %0d want 16", fifo_cnt); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
    extra = 8'($urandom);
    @(negedge clk);
    rate_hold = 1'b0;
    wr_en = 1'b1;
    wr_data = extra;
    @(negedge clk);
    wr_en = 1'b0;
    exp_q.push_back(extra);
    checks++; if (fifo_cnt !== 5'd16 || overflow !== 1'b0)
      begin errors++; $display("FAIL ovf_full_pop_write: got cnt=%0d ovf=%b want 16 0", fifo_cnt, overflow); end
    for (int i = 0; i < 17; i++) begin
      recv_frame(model_div, (i == 0), -1, 2'b00, d, gap, ok);
      e = exp_q.pop_front();
      checks++; if (ok !== 1'b1 || gap !== 0 || d !== e)
        begin errors++; $display("FAIL ovf_frame%0d: got ok=%b gap=%0d data=%h want ok=1 gap=0 data=%h", i, ok, gap, d, e); end
    end
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    checks++; if (lows !== 0 || fifo_empty !== 1'b1)
      begin errors++; $display("FAIL ovf_drained: got lows=%0d empty=%b want 0 1", lows, fifo_empty); end
  endtask

  task automatic test_clean;
    logic ov;
    logic [7:0] d, e;
    int n, gap;
    bit ok;
    commit_rate(2'b11);
    set_hold(1'b1);
    for (int i = 0; i < 6; i++) write_byte(8'($urandom), ov);
    set_hold(1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd !== 1'b0 && n < 50);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL clean_start: got %b want 0", txd); end
    repeat (4*DF + 1) @(negedge clk);
    clean = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h55;
    finish = 1'b1;
    rate_sel = 2'b11;
    @(negedge clk);
    clean = 1'b0;
    wr_en = 1'b0;
    finish = 1'b0;
    exp_q.delete();
    model_div = DS;
    checks++; if (txd !== 1'b1 || tx_busy !== 1'b0)
      begin errors++; $display("FAIL clean_line: got txd=%b busy=%b want 1 0", txd, tx_busy); end
    checks++; if (fifo_cnt !== 5'd0 || fifo_empty !== 1'b1 || overflow !== 1'b0)
      begin errors++; $display("FAIL clean_fifo: got cnt=%0d empty=%b ovf=%b want 0 1 0", fifo_cnt, fifo_empty, overflow); end
    write_byte(8'($urandom), ov);
    recv_frame(model_div, 1'b0, -1, 2'b00, d, gap, ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || gap !== 0 || d !== e)
      begin errors++; $display("FAIL clean_after: got ok=%b gap=%0d data=%h want ok=1 gap=0 data=%h", ok, gap, d, e); end
  endtask

  task automatic test_rate_change;
    logic ov;
    logic [7:0] d, e;
    int gap;
    bit ok;
    commit_rate(2'b11);
    set_hold(1'b1);
    write_byte(8'($urandom), ov);
    write_byte(8'($urandom), ov);
    set_hold(1'b0);
    recv_frame(DF, 1'b0, 10, 2'b01, d, gap, ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || d !== e)
      begin errors++; $display("FAIL rate_inflight: got ok=%b data=%h want ok=1 data=%h", ok, d, e); end
    model_div = map_div(2'b01);
    recv_frame(model_div, 1'b0, -1, 2'b00, d, gap, ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || gap !== 0 || d !== e)
      begin errors++; $display("FAIL rate_next: got ok=%b gap=%0d data=%h want ok=1 gap=0 data=%h", ok, gap, d, e); end
  endtask

  task automatic test_random_rates;
    logic ov;
    logic [7:0] d, e;
    int n, gap;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      set_hold(1'b1);
      commit_rate(2'($urandom_range(0, 3)));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) write_byte(8'($urandom), ov);
      set_hold(1'b0);
      for (int i = 0; i < n; i++) begin
        recv_frame(model_div, 1'b0, -1, 2'b00, d, gap, ok);
        e = exp_q.pop_front();
        checks++; if (ok !== 1'b1 || gap !== 0 || d !== e)
          begin errors++; $display("FAIL rand_%0d_%0d: got ok=%b gap=%0d data=%h want ok=1 gap=0 data=%h div=%0d", it, i, ok, gap, d, e, model_div); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic ov;
    logic [7:0] d, e;
    int gap;
    bit ok;
    commit_rate(2'b01);
    set_hold(1'b1);
    write_byte(8'($urandom), ov);
    write_byte(8'($urandom), ov);
    set_hold(1'b0);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (txd !== 1'b1 || tx_busy !== 1'b0 || fifo_cnt !== 5'd0)
      begin errors++; $display("FAIL async_reset: got txd=%b busy=%b cnt=%0d want 1 0 0", txd, tx_busy, fifo_cnt); end
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    model_div = DS;
    write_byte(8'($urandom), ov);
    recv_frame(model_div, 1'b0, -1, 2'b00, d, gap, ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || gap !== 0 || d !== e)
      begin errors++; $display("FAIL reset_after: got ok=%b gap=%0d data=%h want ok=1 gap=0 data=%h", ok, gap, d, e); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_hold_contiguous();
    test_overflow();
    test_clean();
    test_rate_change();
    test_random_rates();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
